// File: rtl/regfile_dump_tx.sv
// Register-file dump initiator: sweeps an inclusive address range and sends it
// as a framed byte stream (header, MSB-first payload bytes, XOR checksum).
module regfile_dump_tx #(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 5,
  parameter int          REG_DEPTH  = 32,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  // tx handshake: a byte moves on a posedge with tx_valid & tx_ready; once
  // tx_valid rises, tx_valid and tx_data hold until that transfer (or rst).

  localparam int BPW = DATA_WIDTH / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_BYTES = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (REG_DEPTH != 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("REG_DEPTH must equal 2**ADDR_WIDTH");
  end

  logic [2:0]            state;
  logic [7:0]            checksum;
  logic [DATA_WIDTH-1:0] word_sr;
  logic [DATA_WIDTH-1:0] word_shift;
  logic [CW-1:0]         byte_cnt;
  logic [ADDR_WIDTH-1:0] regs_left;
  logic                  xfer;

  assign xfer       = tx_valid & tx_ready;
  assign word_shift = word_sr << 8;

  // regs_left counts registers still to fetch after the current one; the
  // natural ADDR_WIDTH wrap gives the mod-REG_DEPTH range length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rf_read_addr <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      checksum     <= '0;
      word_sr      <= '0;
      byte_cnt     <= '0;
      regs_left    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            regs_left    <= last_addr - first_addr;
            rf_read_addr <= first_addr;
            checksum     <= '0;
            busy         <= 1'b1;
            tx_data      <= HDR_BYTE;
            tx_valid     <= 1'b1;
            state        <= S_HDR;
          end
        end
        S_HDR: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          word_sr  <= rf_read_data;
          tx_data  <= rf_read_data[DATA_WIDTH-1 -: 8];
          tx_valid <= 1'b1;
          byte_cnt <= LAST_BYTE;
          state    <= S_BYTES;
        end
        S_BYTES: begin
          if (xfer) begin
            checksum <= checksum ^ tx_data;
            if (byte_cnt != '0) begin
              byte_cnt <= byte_cnt - 1'b1;
              word_sr  <= word_shift;
              tx_data  <= word_shift[DATA_WIDTH-1 -: 8];
            end else if (regs_left != '0) begin
              regs_left    <= regs_left - 1'b1;
              rf_read_addr <= rf_read_addr + 1'b1;
              tx_valid     <= 1'b0;
              state        <= S_FETCH;
            end else begin
              // The final payload byte is folded in here, same cycle it leaves.
              tx_data <= checksum ^ tx_data;
              state   <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx: a register-file model feeds the DUT, tests queue
// expected frame bytes and a monitor pops and compares every transferred byte.
module tb_regfile_dump_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rf_read_addr;
  logic [15:0] rf_read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [15:0] regs [0:31];
  assign rf_read_data = regs[rf_read_addr];

  always #5 clk = ~clk;

  regfile_dump_tx #(
    .DATA_WIDTH(16), .ADDR_WIDTH(5), .REG_DEPTH(32), .HDR_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  // Entry: {check_addr, addr[4:0], byte[7:0]}
  logic [13:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int frame_bytes = 0;
  bit bp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back({1'b0, 5'd0, b});
  endtask

  task automatic push_pay(input logic [4:0] a, input logic [7:0] b);
    exp_q.push_back({1'b1, a, b});
  endtask

  task automatic push_basic();
    push_byte(8'hA5);
    push_pay(5'd0, 8'h12); push_pay(5'd0, 8'h34);
    push_pay(5'd1, 8'hAB); push_pay(5'd1, 8'hCD);
    push_byte(8'h40);
  endtask

  // tx_ready driver
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples mid-cycle; a byte with valid & ready here transfers at the next posedge.
  initial begin : monitor
    logic       pv, pr;
    logic [7:0] pd;
    logic [13:0] e;
    pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_data", 32'(tx_data), 32'(pd));
        end
        if (done) done_cnt++;
        if (tx_valid && tx_ready) begin
          frame_bytes++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'(tx_data), 32'(e[7:0]));
            if (e[13]) check("rf_addr", 32'(rf_read_addr), 32'(e[12:8]));
          end
        end
        pv = tx_valid; pr = tx_ready; pd = tx_data;
      end
    end
  end

  task automatic start_frame(input logic [4:0] f, input logic [4:0] l);
    frame_bytes = 0;
    @(negedge clk);
    start = 1'b1; first_addr = f; last_addr = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (frame_bytes < n && k < 500) begin
      @(negedge clk); #2;
      k++;
    end
    check("wait_bytes", 32'(frame_bytes >= n), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int base, n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < 3000) begin
      @(negedge clk); #2;
      n++;
    end
    check({name, "_done_seen"}, 32'(done_cnt != base), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    check({name, "_done_once"}, 32'(done_cnt - base), 32'd1);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin : stim
    logic [7:0] chk;
    logic [4:0] a;
    rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(rf_read_addr), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame
    regs[0] = 16'h1234; regs[1] = 16'hABCD;
    push_basic();
    start_frame(5'd0, 5'd1);
    wait_done("basic");
    check("basic_len", 32'(frame_bytes), 32'd6);

    // Wrap-around 31 -> 0
    regs[31] = 16'h00FF; regs[0] = 16'h0F0F;
    push_byte(8'hA5);
    push_pay(5'd31, 8'h00); push_pay(5'd31, 8'hFF);
    push_pay(5'd0, 8'h0F);  push_pay(5'd0, 8'h0F);
    push_byte(8'hFF);
    start_frame(5'd31, 5'd0);
    wait_done("wrap");

    // Single register
    regs[5] = 16'h8001;
    push_byte(8'hA5);
    push_pay(5'd5, 8'h80); push_pay(5'd5, 8'h01);
    push_byte(8'h81);
    start_frame(5'd5, 5'd5);
    wait_done("single");
    check("single_len", 32'(frame_bytes), 32'd4);

    // Full sweep 3..2 (all 32 registers)
    for (int i = 0; i < 32; i++) regs[i] = {8'(i * 3), 8'(8'hF0 ^ i)};
    chk = '0;
    push_byte(8'hA5);
    for (int k = 0; k < 32; k++) begin
      a = 5'(3 + k);
      push_pay(a, regs[a][15:8]);
      push_pay(a, regs[a][7:0]);
      chk = chk ^ regs[a][15:8] ^ regs[a][7:0];
    end
    push_byte(chk);
    start_frame(5'd3, 5'd2);
    wait_done("full");
    check("full_len", 32'(frame_bytes), 32'd66);
    check("full_addr_hold", 32'(rf_read_addr), 32'd2);

    // Backpressure
    regs[0] = 16'h1234; regs[1] = 16'hABCD;
    bp_en = 1'b1;
    push_basic();
    start_frame(5'd0, 5'd1);
    wait_done("backpressure");
    bp_en = 1'b0;

    // Start while busy is ignored
    regs[5] = 16'h8001;
    push_basic();
    start_frame(5'd0, 5'd1);
    wait_bytes(2);
    @(negedge clk);
    start = 1'b1; first_addr = 5'd5; last_addr = 5'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_busy");

    // Reset after the third byte
    push_basic();
    start_frame(5'd0, 5'd1);
    wait_bytes(3);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", 32'(rf_read_addr), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    push_basic();
    start_frame(5'd0, 5'd1);
    wait_done("after_rst");
    check("after_rst_len", 32'(frame_bytes), 32'd6);

    // Write to regs[1] while word 0 is transmitting
    push_byte(8'hA5);
    push_pay(5'd0, 8'h12); push_pay(5'd0, 8'h34);
    push_pay(5'd1, 8'h55); push_pay(5'd1, 8'h55);
    push_byte(8'h26);
    start_frame(5'd0, 5'd1);
    wait_bytes(2);
    @(negedge clk);
    regs[1] = 16'h5555;
    wait_done("write_during");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
